exception_unit: RTL
===================

// Module: exception_unit
// PURPOSE
//  MEM-stage exception arbiter directly upstream of cp0. Synchronises external interrupt lines into cp0 int_i.
//  Prioritises the per-instruction exception flags and registers the winner as excepttype/EPC-source/badvaddr for cp0.
//  Drives the pipeline flush and redirect PC (exception vector or EPC on eret) through a small flush FSM.
// PARAMETERS
//  EXC_VECTOR    32'hBFC00380  redirect PC for every exception except eret
//  FLUSH_CYCLES  1             cycles flush_o is held high per commit (1..15)
// PORTS
//  clk                 in   1   clock; all state updates on posedge
//  rst                 in   1   asynchronous, active-high reset
//  stall_i             in   1   MEM stage stalled; no commit while high
//  ext_int_i           in   6   raw asynchronous hardware interrupt lines
//  inst_valid_i        in   1   MEM holds a real (non-bubble) instruction
//  pc_i                in   32  PC of MEM instruction
//  in_delayslot_i      in   1   MEM instruction is in a delay slot
//  adel_if_i           in   1   fetch address misaligned
//  ri_i                in   1   reserved instruction
//  syscall_i           in   1   syscall
//  break_i             in   1   break
//  ov_i                in   1   arithmetic overflow
//  trap_i              in   1   trap condition true (used only with EXC_TRAP_EN)
//  adel_i              in   1   load address misaligned
//  ades_i              in   1   store address misaligned
//  eret_i              in   1   eret
//  bad_mem_addr_i      in   32  data address of the MEM load/store
//  status_i            in   32  cp0 Status (mtc0-forwarded)
//  cause_i             in   32  cp0 Cause (mtc0-forwarded)
//  epc_i               in   32  cp0 EPC (mtc0-forwarded)
//  int_o               out  6   synchronised interrupts -> cp0 int_i
//  excepttype_o        out  32  -> cp0 excepttype_i
//  current_inst_addr_o out  32  -> cp0 current_inst_addr_i
//  is_in_delayslot_o   out  1   -> cp0 is_in_delayslot_i
//  bad_addr_o          out  32  -> cp0 bad_addr_i
//  flush_o             out  1   flush IF..MEM pipeline registers
//  newpc_o             out  32  redirect PC, valid while flush_o=1
// BEHAVIOUR
//  - Reset: all outputs 0, sync flops 0, FSM=IDLE, flush counter 0. A reset mid-FLUSH aborts it immediately.
//  - int_o: 2-flop synchroniser per line; ext_int_i change visible on int_o 2 cycles later.
//  - Interrupt pending = status_i[0] & ~status_i[1] & |(cause_i[15:8] & status_i[15:8]).
//  - Detection is combinational and considered only when FSM=IDLE, stall_i=0 and inst_valid_i=1.
//  - Priority, highest first:
//    int 0x01 > adel_if 0x04 > ri 0x0a > syscall 0x08 > break 0x09 > ov 0x0c > [trap 0x0d] > adel 0x04 > ades 0x05 > eret 0x0e.
//  - Commit (any detected type): registered at the edge; in the next cycle (1-cycle latency):
//    - excepttype_o = type; current_inst_addr_o = pc_i; is_in_delayslot_o = in_delayslot_i
//    - bad_addr_o = pc_i for adel_if, bad_mem_addr_i for adel/ades, else holds its previous value
//    - flush_o = 1; newpc_o = epc_i for eret, else EXC_VECTOR
//  - FSM IDLE -> FLUSH on commit. FLUSH lasts FLUSH_CYCLES cycles (4-bit down counter), then -> IDLE.
//  - excepttype_o is nonzero only in the first FLUSH cycle and is 0 at all other times, so cp0 acts exactly once.
//  - flush_o and newpc_o hold for the whole of FLUSH. newpc_o is 0 in IDLE.
//  - In FLUSH, inputs are ignored: MEM is being flushed and no back-to-back commits occur.
//  - stall_i=1 in IDLE: no commit; detection re-evaluates each cycle on the held inputs.
//  - An interrupt with inst_valid_i=0 (bubble) waits for the next valid instruction.
//  - Multiple flags set together: only the highest-priority one commits; the rest are discarded.
// CONFIGURATION
//  - EXC_TRAP_EN defined: trap_i participates in arbitration as type 32'h0000000d at the slot shown.
//  - EXC_TRAP_EN undefined: trap_i is ignored and 0x0d is never produced.
// TESTING
//  - Reset, then ext_int_i=6'b000001 at cycle 0 -> int_o=6'b000001 from cycle 2. Assert rst -> all outputs 0 at once.
//  - status_i=32'h0000_0401, cause_i[10]=1, valid insn at pc 0x80001000:
//    next cycle excepttype_o=0x1, current_inst_addr_o=0x80001000, flush_o=1, newpc_o=0xBFC00380.
//  - adel_if_i=1 and syscall_i=1 together at pc 0x80000002 -> excepttype_o=0x4, bad_addr_o=0x80000002 (fetch wins).
//  - ades_i=1, bad_mem_addr_i=0x10000003, in_delayslot_i=1, stall_i=1 for 3 cycles:
//    no flush until stall_i drops; then excepttype_o=0x5, is_in_delayslot_o=1.
//  - eret_i=1, epc_i=0x80002000, FLUSH_CYCLES=3 -> flush_o high 3 cycles with newpc_o=0x80002000;
//    excepttype_o=0xe for the first cycle only.
//  - trap_i=1 alone: with EXC_TRAP_EN -> excepttype_o=0xd and flush; without it -> no flush, excepttype_o stays 0.

Source files
------------

// File: rtl/exception_unit.sv
// MEM-stage exception arbiter feeding cp0: interrupt synchroniser, priority encoder and flush FSM.
// Define EXC_TRAP_EN to let trap_i take part in arbitration (type 0x0d).
module exception_unit #(
   parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380,
   parameter int          FLUSH_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall_i,
   input  logic [5:0]  ext_int_i,
   input  logic        inst_valid_i,
   input  logic [31:0] pc_i,
   input  logic        in_delayslot_i,
   input  logic        adel_if_i,
   input  logic        ri_i,
   input  logic        syscall_i,
   input  logic        break_i,
   input  logic        ov_i,
   input  logic        trap_i,
   input  logic        adel_i,
   input  logic        ades_i,
   input  logic        eret_i,
   input  logic [31:0] bad_mem_addr_i,
   input  logic [31:0] status_i,
   input  logic [31:0] cause_i,
   input  logic [31:0] epc_i,
   output logic [5:0]  int_o,
   output logic [31:0] excepttype_o,
   output logic [31:0] current_inst_addr_o,
   output logic        is_in_delayslot_o,
   output logic [31:0] bad_addr_o,
   output logic        flush_o,
   output logic [31:0] newpc_o
);

   typedef enum logic {IDLE, FLUSH} state_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [5:0]  int_meta_q, int_q;
   logic [31:0] excepttype_q, excepttype_d;
   logic [31:0] inst_addr_q, inst_addr_d;
   logic        delayslot_q, delayslot_d;
   logic [31:0] bad_addr_q, bad_addr_d;
   logic        flush_q, flush_d;
   logic [31:0] newpc_q, newpc_d;

   logic        int_pending;
   logic        bad_from_pc;
   logic        bad_from_mem;
   logic [31:0] exc_type;
   logic        commit;
   logic        unused_ok;

`ifdef EXC_TRAP_EN
   assign unused_ok = ^{status_i[31:16], status_i[7:2], cause_i[31:16], cause_i[7:0]};
`else
   assign unused_ok = ^{status_i[31:16], status_i[7:2], cause_i[31:16], cause_i[7:0], trap_i};
`endif

   // Fixed-priority encoder; every winning type is nonzero, so zero means "nothing to take".
   always_comb begin
      int_pending  = status_i[0] & ~status_i[1] & (|(cause_i[15:8] & status_i[15:8]));
      exc_type     = 32'h0;
      bad_from_pc  = 1'b0;
      bad_from_mem = 1'b0;
      if (int_pending) begin
         exc_type = 32'h01;
      end else if (adel_if_i) begin
         exc_type    = 32'h04;
         bad_from_pc = 1'b1;
      end else if (ri_i) begin
         exc_type = 32'h0a;
      end else if (syscall_i) begin
         exc_type = 32'h08;
      end else if (break_i) begin
         exc_type = 32'h09;
      end else if (ov_i) begin
         exc_type = 32'h0c;
`ifdef EXC_TRAP_EN
      end else if (trap_i) begin
         exc_type = 32'h0d;
`endif
      end else if (adel_i) begin
         exc_type     = 32'h04;
         bad_from_mem = 1'b1;
      end else if (ades_i) begin
         exc_type     = 32'h05;
         bad_from_mem = 1'b1;
      end else if (eret_i) begin
         exc_type = 32'h0e;
      end
      commit = (state_q == IDLE) & ~stall_i & inst_valid_i & (exc_type != 32'h0);
   end

   // excepttype defaults to zero so cp0 sees the exception in the first FLUSH cycle only.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      excepttype_d = 32'h0;
      inst_addr_d  = inst_addr_q;
      delayslot_d  = delayslot_q;
      bad_addr_d   = bad_addr_q;
      flush_d      = flush_q;
      newpc_d      = newpc_q;
      if (state_q == IDLE) begin
         if (commit) begin
            state_d      = FLUSH;
            cnt_d        = 4'(FLUSH_CYCLES - 1);
            excepttype_d = exc_type;
            inst_addr_d  = pc_i;
            delayslot_d  = in_delayslot_i;
            flush_d      = 1'b1;
            newpc_d      = (exc_type == 32'h0e) ? epc_i : EXC_VECTOR;
            if (bad_from_pc) begin
               bad_addr_d = pc_i;
            end else if (bad_from_mem) begin
               bad_addr_d = bad_mem_addr_i;
            end
         end
      end else begin
         if (cnt_q == 4'd0) begin
            state_d = IDLE;
            flush_d = 1'b0;
            newpc_d = 32'h0;
         end else begin
            cnt_d = cnt_q - 4'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         cnt_q        <= 4'd0;
         int_meta_q   <= 6'd0;
         int_q        <= 6'd0;
         excepttype_q <= 32'h0;
         inst_addr_q  <= 32'h0;
         delayslot_q  <= 1'b0;
         bad_addr_q   <= 32'h0;
         flush_q      <= 1'b0;
         newpc_q      <= 32'h0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         int_meta_q   <= ext_int_i;
         int_q        <= int_meta_q;
         excepttype_q <= excepttype_d;
         inst_addr_q  <= inst_addr_d;
         delayslot_q  <= delayslot_d;
         bad_addr_q   <= bad_addr_d;
         flush_q      <= flush_d;
         newpc_q      <= newpc_d;
      end
   end

   assign int_o               = int_q;
   assign excepttype_o        = excepttype_q;
   assign current_inst_addr_o = inst_addr_q;
   assign is_in_delayslot_o   = delayslot_q;
   assign bad_addr_o          = bad_addr_q;
   assign flush_o             = flush_q;
   assign newpc_o             = newpc_q;

endmodule
